tile_map_writer: RTL and testbench

- Owns the 20x20 tile map that the colour mapper renders; game logic writes tiles here through a valid/ready port.
- Double-buffered. Writes and fills go to a back buffer. The front buffer drives outMapData and is updated only on frame_end, so a frame never shows a partial map.
- Includes a bulk-fill engine (one tile per clock) for level clear/load.

---
 rtl/tile_map_writer.sv | 99 +++++++++
 tb/tb_tile_map_writer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tile_map_writer.sv
// tile_map_writer: double-buffered 20x20 tile map with a valid/ready write port, bulk fill and vsync-timed swap.
// Optional macro TILE_MAP_ANIM_EN animates tiles in the front buffer every ANIM_PERIOD frames.
module tile_map_writer #(
  parameter int MAP_W = 20,
  parameter int MAP_H = 20,
  parameter int TILE_BITS = 5
`ifdef TILE_MAP_ANIM_EN
  , parameter int ANIM_PERIOD = 8
`endif
) (
  input  logic                                    Clk,
  input  logic                                    reset,
  input  logic                                    wr_valid,
  output logic                                    wr_ready,
  input  logic [4:0]                              wr_row,
  input  logic [4:0]                              wr_col,
  input  logic [TILE_BITS-1:0]                    wr_tile,
  input  logic                                    fill_start,
  input  logic [TILE_BITS-1:0]                    fill_tile,
  input  logic                                    frame_end,
  output logic                                    busy,
  output logic                                    dirty,
  output logic                                    oob_err,
  output logic                                    swapped,
  output logic [0:MAP_W*MAP_H-1][TILE_BITS-1:0]   outMapData
);
  localparam int N = MAP_W * MAP_H;
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nxt;
  logic [TILE_BITS-1:0] back [N];
  logic [0:N-1][TILE_BITS-1:0] front_nxt;
  logic [IW-1:0] fill_idx, wr_idx;
  logic [TILE_BITS-1:0] fill_val;
  logic wr_in, wr_ok, wr_oob, swap, fill_last, pulse;
  assign wr_ready  = state == IDLE && !reset && !fill_start;
  assign wr_idx    = IW'(wr_row) * IW'(MAP_W) + IW'(wr_col);
  assign wr_in     = wr_row < 5'(MAP_H) && wr_col < 5'(MAP_W);
  assign wr_ok     = wr_valid && wr_ready && wr_in;
  assign wr_oob    = wr_valid && wr_ready && !wr_in;
  assign swap      = frame_end && state == IDLE && dirty;
  assign fill_last = fill_idx == IW'(N - 1);
  assign busy      = state == FILL;
  always_ff @(posedge Clk) state <= reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (fill_start ? FILL : IDLE) : (fill_last ? IDLE : FILL);
  end
`ifdef TILE_MAP_ANIM_EN
  localparam int CW = ANIM_PERIOD > 1 ? $clog2(ANIM_PERIOD) : 1;
  logic [CW-1:0] frame_cnt;
  logic anim;
  assign anim  = frame_end && frame_cnt == CW'(ANIM_PERIOD - 1);
  assign pulse = swap || anim;
  always_ff @(posedge Clk) begin
    if (reset) frame_cnt <= '0;
    else if (frame_end) frame_cnt <= anim ? '0 : frame_cnt + 1'b1;
  end
  // imp frames toggle 3<->4, swamp cycles 10->11->12->13->10
  function automatic logic [TILE_BITS-1:0] step(input logic [TILE_BITS-1:0] t);
    return t == TILE_BITS'(3)  ? TILE_BITS'(4)  :
           t == TILE_BITS'(4)  ? TILE_BITS'(3)  :
           t == TILE_BITS'(10) ? TILE_BITS'(11) :
           t == TILE_BITS'(11) ? TILE_BITS'(12) :
           t == TILE_BITS'(12) ? TILE_BITS'(13) :
           t == TILE_BITS'(13) ? TILE_BITS'(10) : t;
  endfunction
`else
  assign pulse = swap;
`endif
  // animation, when enabled, is applied on top of freshly swapped data
  always_comb begin
    for (int i = 0; i < N; i++) begin
      front_nxt[i] = swap ? back[i] : outMapData[i];
`ifdef TILE_MAP_ANIM_EN
      if (anim) front_nxt[i] = step(front_nxt[i]);
`endif
    end
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) back[i] <= '0;
      outMapData <= '0;
      dirty      <= 1'b0;
      oob_err    <= 1'b0;
      swapped    <= 1'b0;
      fill_idx   <= '0;
      fill_val   <= '0;
    end else begin
      if (busy) back[fill_idx] <= fill_val;
      else if (wr_ok) back[wr_idx] <= wr_tile;
      outMapData <= front_nxt;
      dirty      <= wr_ok || (busy && fill_last) || (dirty && !swap);
      oob_err    <= oob_err || wr_oob;
      swapped    <= pulse;
      fill_idx   <= busy && !fill_last ? fill_idx + 1'b1 : '0;
      if (!busy && fill_start) fill_val <= fill_tile;
    end
  end
endmodule

// File: tb/tb_tile_map_writer.sv
// tb_tile_map_writer: directed, table-driven bench for tile_map_writer.
module tb_tile_map_writer;
  logic Clk = 1'b0, reset = 1'b1, wr_valid = 1'b0, fill_start = 1'b0, frame_end = 1'b0;
  logic [4:0] wr_row = '0, wr_col = '0, wr_tile = '0, fill_tile = '0;
  logic wr_ready, busy, dirty, oob_err, swapped;
  logic [0:399][4:0] outMapData;
  int n_chk = 0, n_fail = 0;

  tile_map_writer dut (
    .Clk(Clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_tile(wr_tile),
    .fill_start(fill_start), .fill_tile(fill_tile), .frame_end(frame_end),
    .busy(busy), .dirty(dirty), .oob_err(oob_err), .swapped(swapped),
    .outMapData(outMapData)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0] row;
    logic [4:0] col;
    logic [4:0] tile;
    int         idx;
    logic       oob;
    logic       exp_oob;
  } vec_t;
  vec_t vecs[8];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic write(input logic [4:0] r, input logic [4:0] c, input logic [4:0] t);
    wr_valid = 1'b1; wr_row = r; wr_col = c; wr_tile = t;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("ready_in_reset", wr_ready, 0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int cnt, rdy_bad, sw_seen, bad;
    vecs[0] = '{5'd0,  5'd0,  5'd14, 0,   1'b0, 1'b0};
    vecs[1] = '{5'd19, 5'd19, 5'd6,  399, 1'b0, 1'b0};
    vecs[2] = '{5'd0,  5'd19, 5'd8,  19,  1'b0, 1'b0};
    vecs[3] = '{5'd19, 5'd0,  5'd9,  380, 1'b0, 1'b0};
    vecs[4] = '{5'd20, 5'd0,  5'd5,  -1,  1'b1, 1'b1};
    vecs[5] = '{5'd0,  5'd25, 5'd5,  -1,  1'b1, 1'b1};
    vecs[6] = '{5'd31, 5'd31, 5'd1,  -1,  1'b1, 1'b1};
    vecs[7] = '{5'd10, 5'd10, 5'd15, 210, 1'b0, 1'b1};

    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_oob", oob_err, 0);
    chk("rst_swapped", swapped, 0);
    chk("rst_map0", outMapData[0], 0);
    chk("rst_ready", wr_ready, 1);

    write(5'd2, 5'd3, 5'd7);
    chk("w1_dirty", dirty, 1);
    chk("w1_map43_pre", outMapData[43], 0);
    frame();
    chk("w1_map43", outMapData[43], 7);
    chk("w1_swapped", swapped, 1);
    chk("w1_dirty_clr", dirty, 0);
    tick();
    chk("w1_swapped_drop", swapped, 0);

    for (int k = 0; k < 8; k++) begin
      write(vecs[k].row, vecs[k].col, vecs[k].tile);
      chk($sformatf("vec%0d_dirty", k), dirty, vecs[k].oob ? 0 : 1);
      chk($sformatf("vec%0d_oob", k), oob_err, vecs[k].exp_oob);
      frame();
      chk($sformatf("vec%0d_swapped", k), swapped, vecs[k].oob ? 0 : 1);
      if (!vecs[k].oob) chk($sformatf("vec%0d_data", k), outMapData[vecs[k].idx], vecs[k].tile);
    end
    chk("oob_nowrite25", outMapData[25], 0);

    write(5'd5, 5'd5, 5'd1);
    repeat (100) tick();
    chk("hold_map105", outMapData[105], 0);
    chk("hold_dirty", dirty, 1);
    frame();
    chk("hold_map105_swap", outMapData[105], 1);

    fill_start = 1'b1; fill_tile = 5'd2;
    tick();
    fill_start = 1'b0;
    cnt = 0; rdy_bad = 0; sw_seen = 0;
    while (busy && cnt < 1000) begin
      if (wr_ready) rdy_bad++;
      if (swapped) sw_seen++;
      frame_end = cnt == 200;
      fill_start = cnt == 100;
      fill_tile = cnt == 100 ? 5'd7 : 5'd2;
      cnt++;
      tick();
    end
    frame_end = 1'b0; fill_start = 1'b0;
    chk("fill_cycles", cnt, 400);
    chk("fill_ready_low", rdy_bad, 0);
    chk("fill_no_swap", sw_seen, 0);
    chk("fill_dirty", dirty, 1);
    chk("fill_front_old", outMapData[0], 14);
    frame();
    bad = 0;
    for (int i = 0; i < 400; i++) if (outMapData[i] != 5'd2) bad++;
    chk("fill_all_2_bad", bad, 0);
    chk("oob_sticky", oob_err, 1);

    write(5'd1, 5'd1, 5'd5);
    wr_valid = 1'b1; wr_row = 5'd0; wr_col = 5'd0; wr_tile = 5'd9; frame_end = 1'b1;
    tick();
    wr_valid = 1'b0; frame_end = 1'b0;
    chk("race_map0_old", outMapData[0], 2);
    chk("race_map21", outMapData[21], 5);
    chk("race_dirty", dirty, 1);
    chk("race_swapped", swapped, 1);
    frame();
    chk("race_map0_new", outMapData[0], 9);

    fill_start = 1'b1; fill_tile = 5'd6;
    tick();
    fill_start = 1'b0;
    repeat (10) tick();
    do_reset();
    chk("abort_busy", busy, 0);
    chk("abort_dirty", dirty, 0);
    chk("abort_oob", oob_err, 0);
    chk("abort_map0", outMapData[0], 0);
    write(5'd0, 5'd1, 5'd1);
    frame();
    chk("abort_back0", outMapData[0], 0);
    chk("abort_back1", outMapData[1], 1);

    do_reset();
    write(5'd0, 5'd0, 5'd3);
    write(5'd0, 5'd1, 5'd10);
    repeat (8) frame();
`ifdef TILE_MAP_ANIM_EN
    chk("anim8_swapped", swapped, 1);
    chk("anim8_map0", outMapData[0], 4);
    chk("anim8_map1", outMapData[1], 11);
`else
    chk("anim8_swapped", swapped, 0);
    chk("anim8_map0", outMapData[0], 3);
    chk("anim8_map1", outMapData[1], 10);
`endif
    repeat (8) frame();
`ifdef TILE_MAP_ANIM_EN
    chk("anim16_map0", outMapData[0], 3);
    chk("anim16_map1", outMapData[1], 12);
`else
    chk("anim16_map0", outMapData[0], 3);
    chk("anim16_map1", outMapData[1], 10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
